quad_nor_tester: RTL and testbench

- Self-test sequencer for an external quad 2-input NOR device (74HC02 pinout: four independent gates, Yn = ~(An | Bn)).
- On `start`, drives all four truth-table vectors onto the DUT A/B pins and waits a settle time after each one.
- Samples the DUT Y pins through a synchroniser, compares them with expected values, and reports a per-gate fail mask plus an overall pass flag.
- Sits between the lab-board push-button/LED logic and the DUT socket pins.

---
 rtl/quad_nor_tester_pkg.sv | 19 +
 rtl/quad_nor_sync2.sv | 27 ++
 rtl/quad_nor_tester.sv | 134 +++++++++++++
 tb/tb_quad_nor_tester.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_nor_tester_pkg.sv
// Shared types, constants and the NOR truth-table helper for the quad NOR self-tester.
package quad_nor_tester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VEC = 4;
  localparam int GATES   = 4;

  // Both inputs low is the only vector that drives every NOR output high.
  function automatic logic [GATES-1:0] exp_y(input logic [1:0] vec);
    return (vec == 2'd0) ? 4'b1111 : 4'b0000;
  endfunction

endpackage

// File: rtl/quad_nor_sync2.sv
// Two-flop synchroniser bringing the asynchronous DUT Y pins into the clk domain.
module quad_nor_sync2
  import quad_nor_tester_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [GATES-1:0] d,
  output logic [GATES-1:0] q
);

  logic [GATES-1:0] meta_q;
  logic [GATES-1:0] sync_q;

  // Metastability-settling register chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'b0000;
      sync_q <= 4'b0000;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/quad_nor_tester.sv
// Self-test sequencer for an external quad 2-input NOR (74HC02 pinout).
// Define QUAD_NOR_TESTER_LOOP_EN for continuous soak mode (repeats until rst).
module quad_nor_tester
  import quad_nor_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GATES-1:0] dut_y,
  output logic [GATES-1:0] dut_a,
  output logic [GATES-1:0] dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [GATES-1:0] fail_mask
);

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("quad_nor_tester: SETTLE_CYCLES=%0d outside legal range 3..255", SETTLE_CYCLES);
  end

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_VEC   = 2'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [GATES-1:0] fail_mask_q, fail_mask_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [GATES-1:0] dut_a_q, dut_a_d;
  logic [GATES-1:0] dut_b_q, dut_b_d;
  logic [GATES-1:0] ys;

  quad_nor_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_y),
    .q   (ys)
  );

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d       = 2'd0;
          cnt_d       = CNT_RELOAD;
          fail_mask_d = 4'b0000;
          pass_d      = 1'b0;
          state_d     = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        fail_mask_d = fail_mask_q | (ys ^ exp_y(vec_q));
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      DONE: begin
        pass_d = (fail_mask_q == 4'b0000);
        vec_d  = 2'd0;
`ifdef QUAD_NOR_TESTER_LOOP_EN
        cnt_d   = CNT_RELOAD;
        state_d = SETTLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with the state register.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    dut_a_d = {GATES{vec_d[1]}};
    dut_b_d = {GATES{vec_d[0]}};
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      cnt_q       <= 8'd0;
      fail_mask_q <= 4'b0000;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_a_q     <= 4'b0000;
      dut_b_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_quad_nor_tester.sv
// Scoreboard testbench for quad_nor_tester with a fault-injectable NOR device model.
module tb_quad_nor_tester;

`ifdef QUAD_NOR_TESTER_LOOP_EN
  localparam int S = 3;
`else
  localparam int S = 4;
`endif
  localparam int LAT = 4 * (S + 1);

  typedef struct packed {
    logic       pass;
    logic [3:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dut_y, dut_a, dut_b, fail_mask;
  logic       busy, done, pass;
  logic [3:0] sa0_m, sa1_m, or_m;
  int         cyc = 0;
  int         checks;
  int         failures;
  exp_t       sb_q[$];

  quad_nor_tester #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_y     (dut_y),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device model: NOR per gate, optionally replaced by OR, then stuck-at-0/1 overrides.
  function automatic logic [3:0] gate_y(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s0, input logic [3:0] s1,
                                        input logic [3:0] om);
    logic [3:0] o;
    o = a | b;
    return ((((~o) & ~om) | (o & om)) & ~s0) | s1;
  endfunction

  assign dut_y = gate_y(dut_a, dut_b, sa0_m, sa1_m, or_m);

  function automatic exp_t predict();
    exp_t       e;
    logic [3:0] m;
    logic [1:0] vv;
    m = 4'b0000;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      m = m | (gate_y({4{vv[1]}}, {4{vv[0]}}, sa0_m, sa1_m, or_m) ^ ((v == 0) ? 4'b1111 : 4'b0000));
    end
    e.mask = m;
    e.pass = (m == 4'b0000);
    return e;
  endfunction

  task automatic set_faults(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] om);
    sa0_m = s0;
    sa1_m = s1;
    or_m  = om;
  endtask

  // One start pulse; optional start re-pulse at a given cycle and optional pin-sequence checks.
  task automatic run_one(input int repulse_at, input bit chk_pins);
    int         a_cyc, rel;
    exp_t       e;
    logic [1:0] kb;
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(predict());
    @(negedge clk);
    start = 1'b0;
    a_cyc = cyc;
    rel = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    while (done !== 1'b1 && rel < LAT + 10) begin
      if (chk_pins && (rel % (S + 1)) == 2 && rel < LAT) begin
        kb = 2'(rel / (S + 1));
        checks++;
        if (dut_a !== {4{kb[1]}} || dut_b !== {4{kb[0]}}) begin
          failures++;
          $display("FAIL pins_vec%0d: got a=%b b=%b want a=%b b=%b", kb, dut_a, dut_b, {4{kb[1]}}, {4{kb[0]}});
        end
      end
      start = (rel == repulse_at);
      @(negedge clk);
      rel = cyc - a_cyc;
    end
    start = 1'b0;
    checks++;
    if (rel != LAT) begin
      failures++;
      $display("FAIL done_latency: got %0d want %0d", rel, LAT);
    end
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (fail_mask !== e.mask) begin
      failures++;
      $display("FAIL fail_mask: got %b want %b", fail_mask, e.mask);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_done: got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (pass !== e.pass || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL after_done: got pass=%b busy=%b done=%b want pass=%b busy=0 done=0", pass, busy, done, e.pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, fail_mask, dut_a, dut_b} !== 15'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b pass=%b mask=%b a=%b b=%b want all 0", busy, done, pass, fail_mask, dut_a, dut_b);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good();
    set_faults(4'b0000, 4'b0000, 4'b0000);
    run_one(-1, 1'b1);
  endtask

  task automatic test_stuck_at0();
    set_faults(4'b0100, 4'b0000, 4'b0000);
    run_one(-1, 1'b0);
  endtask

  task automatic test_sa1_or();
    set_faults(4'b0000, 4'b0001, 4'b1000);
    run_one(-1, 1'b0);
  endtask

  task automatic test_restart();
    set_faults(4'b0000, 4'b0000, 4'b0000);
    run_one(7, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   d1, d2;
    exp_t e;
    set_faults(4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(predict());
    sb_q.push_back(predict());
    d1 = -1;
    d2 = -1;
    for (int n = 0; n < 3 * LAT && d2 < 0; n++) begin
      @(negedge clk);
      if (d1 >= 0 && cyc == d1 + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap_busy: got %b want 0", busy);
        end
      end
      if (done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
        end
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        checks++;
        if (fail_mask !== e.mask) begin
          failures++;
          $display("FAIL b2b_mask: got %b want %b", fail_mask, e.mask);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 < 0 || d2 < 0 || d2 - d1 != LAT + 2) begin
      failures++;
      $display("FAIL b2b_spacing: got d1=%0d d2=%0d want spacing %0d", d1, d2, LAT + 2);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midtest();
    int a_cyc;
    set_faults(4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_cyc = cyc;
    while (cyc - a_cyc < 12) @(negedge clk);
    checks++;
    if (dut_a !== 4'b1111 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got a=%b busy=%b want a=1111 busy=1", dut_a, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, fail_mask, dut_a, dut_b} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b pass=%b mask=%b a=%b b=%b want all 0", busy, done, pass, fail_mask, dut_a, dut_b);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_one(-1, 1'b0);
  endtask

  task automatic test_loop();
    int         last, n_done;
    bit         pend_pass, busy_dropped;
    logic [3:0] sticky;
    exp_t       e, p;
    set_faults(4'b0000, 4'b0000, 4'b0000);
    sticky = 4'b0000;
    busy_dropped = 1'b0;
    pend_pass = 1'b0;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    p = predict();
    sticky = sticky | p.mask;
    sb_q.push_back({sticky == 4'b0000, sticky});
    @(negedge clk);
    start = 1'b0;
    last = cyc;
    for (int n = 0; n < 6 * (LAT + 1) && n_done < 4; n++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_dropped = 1'b1;
      if (pend_pass) begin
        pend_pass = 1'b0;
        checks++;
        if (pass !== e.pass) begin
          failures++;
          $display("FAIL loop_pass%0d: got %b want %b", n_done, pass, e.pass);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if (cyc - last != ((n_done == 1) ? LAT : LAT + 1)) begin
          failures++;
          $display("FAIL loop_period%0d: got %0d want %0d", n_done, cyc - last, (n_done == 1) ? LAT : LAT + 1);
        end
        last = cyc;
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        checks++;
        if (fail_mask !== e.mask) begin
          failures++;
          $display("FAIL loop_mask%0d: got %b want %b", n_done, fail_mask, e.mask);
        end
        pend_pass = 1'b1;
        if (n_done == 2) set_faults(4'b0010, 4'b0000, 4'b0000);
        if (n_done == 3) set_faults(4'b0000, 4'b0000, 4'b0000);
        p = predict();
        sticky = sticky | p.mask;
        sb_q.push_back({sticky == 4'b0000, sticky});
      end
    end
    @(negedge clk);
    if (pend_pass) begin
      checks++;
      if (pass !== e.pass) begin
        failures++;
        $display("FAIL loop_pass_last: got %b want %b", pass, e.pass);
      end
    end
    checks++;
    if (n_done != 4 || busy_dropped) begin
      failures++;
      $display("FAIL loop_run: got dones=%0d busy_dropped=%b want dones=4 busy_dropped=0", n_done, busy_dropped);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL loop_exit: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    set_faults(4'b0000, 4'b0000, 4'b0000);
    test_reset();
`ifdef QUAD_NOR_TESTER_LOOP_EN
    test_loop();
`else
    test_good();
    test_stuck_at0();
    test_sa1_or();
    test_restart();
    test_back_to_back();
    test_reset_midtest();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
